can_bit_transmitter: RTL
========================

Name: can_bit_transmitter

Overview:
Transmit-side bit engine for the CAN controller. It is the producer of the edges that the receive-side edge detector sees on the bus. It accepts one logical bit per handshake from the frame serializer, inserts stuff bits, and drives tx_out for exactly one nominal bit time per bit. It also emits tx_point and sample_point strobes so the bit monitor can compare the transmitted bit with the received one.

Parameters:
PRESCALER, 4, clocks per time quantum (TQ); legal range ≥1
TSEG1, 13, TQs in PROP+PHASE1 segment; legal range ≥1
TSEG2, 2, TQs in PHASE2 segment; legal range ≥1
STUFF_LEN, 5, identical consecutive bits that trigger insertion of a stuff bit

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
bit_valid  in  1  serializer presents a bit
bit_data  in  1  bit value (0 = dominant, 1 = recessive)
bit_ready  out  1  engine accepts bit_data this cycle
stuff_en  in  1  stuffing enabled; sampled with each accepted bit
tx_out  out  1  CAN TX line, registered
tx_point  out  1  1-clock pulse on the first clock of every driven bit
sample_point  out  1  1-clock pulse at the sample point of every driven bit
stuff_active  out  1  high for the whole bit period of an inserted stuff bit
busy  out  1  high while a bit (data or stuff) is being driven

Behaviour:
- Interface: one clock domain, "clock". Reset is asynchronous and active-low on "reset_n".
- Reset values: tx_out=1 (recessive), bit_ready=1, tx_point=0, sample_point=0, stuff_active=0, busy=0. All counters are 0 and the FSM is IDLE.
- Reset asserted mid-bit: tx_out returns to 1 immediately, not waiting for a clock edge. The in-flight bit and any pending stuff bit are discarded.
- Bit time NBT = 1+TSEG1+TSEG2 TQs = PRESCALER*NBT clocks.
- Counters: pre_cnt runs 0..PRESCALER-1; tq_idx runs 0..NBT-1.
- bit_end is the clock where tq_idx=NBT-1 and pre_cnt=PRESCALER-1.
- FSM states: IDLE, DATA, STUFF.
- IDLE:
  - tx_out=1, busy=0, bit_ready=1.
  - bit_valid&bit_ready -> DATA on the next edge, with tx_out<=bit_data, counters cleared, tx_point=1 for that first clock.
- DATA / STUFF:
  - busy=1.
  - Counters advance every clock.
  - sample_point=1 on the clock where tq_idx=1+TSEG1 and pre_cnt=0.
  - bit_ready=1 only on the bit_end clock, and only if no stuff bit is pending.
- Back-to-back bits: a handshake on the bit_end clock starts the next bit on the following edge, with no idle gap. tx_point pulses again.
- No handshake at bit_end and no stuff bit pending -> IDLE. tx_out returns to 1 and the run counter clears.
- Stuff rule:
  - run_cnt counts consecutive transmitted bits of equal value, including stuff bits. It saturates at STUFF_LEN.
  - A new bit equal to the last bit gives run_cnt+1; a different bit gives run_cnt=1.
  - When run_cnt reaches STUFF_LEN with the latched stuff_en=1, a stuff bit is pending. bit_ready stays 0 at that bit_end.
  - The next period is STUFF: tx_out=~last bit, stuff_active=1, tx_point pulses. After STUFF, run_cnt=1 with the stuff value.
- stuff_en=0 on an accepted bit: no stuff check for that bit, and run_cnt resets to 0 after it (used for CRC delimiter, ACK, EOF).
- bit_valid deasserted while busy: ignored, and the bit in flight completes. bit_data is sampled only on a handshake.
- Width rules:
  - tq_idx width = $clog2(NBT).
  - pre_cnt width = $clog2(PRESCALER), minimum 1.
  - run_cnt width = $clog2(STUFF_LEN+1).
  - With PRESCALER=1, pre_cnt is constant 0 and each TQ is one clock.

Decomposition:
- Shared package can_timing_pkg holds:
  - state enum tx_state_e {IDLE, DATA, STUFF};
  - constants CAN_RECESSIVE=1'b1 and CAN_DOMINANT=1'b0;
  - a function computing NBT from TSEG1/TSEG2.
- One sub-module, can_tq_counter, holds the prescaler and TQ index counters. Its outputs are tq_idx, bit_end and sample_point; it takes a synchronous restart input.
- The FSM, stuffing logic and handshake live in the top level.

Test Plan:
All scenarios use PRESCALER=2, TSEG1=5, TSEG2=2, which gives 8 TQ and 16 clocks per bit.
1. Reset while tx_out=0 mid-bit -> tx_out=1 before the next clock edge. After release: busy=0, bit_ready=1.
2. Single bit 0 with stuff_en=1, handshake at edge k -> tx_out=0 from edge k+1 to k+16. tx_point pulses at k+1 and sample_point at k+13. tx_out=1 and busy=0 from edge k+17.
3. Stream 1,0,1,0 with continuous bit_valid -> bit_ready pulses every 16 clocks. tx_out toggles every 16 clocks, each bit lasts exactly 16 clocks, and there are no idle clocks between bits.
4. Six zeros with stuff_en=1 -> tx_out shows 0×5, then 1 (stuff_active=1, 16 clocks), then 0. bit_ready is low at the 5th bit_end; the 6th bit is accepted at the stuff bit_end.
5. Five ones with stuff_en=0, then 1 with stuff_en=1 -> no stuff bit is inserted. tx_out stays 1 for 96 clocks.
6. Bits 0,0,0,0,0 with stuff_en=1, bit_valid low afterwards -> stuff bit 1 is still driven for 16 clocks, then IDLE. tx_point fires 6 times in total.

Source files
------------

// File: rtl/can_timing_pkg.sv
// Shared CAN bit-timing definitions: transmitter FSM states, bus levels
// and the nominal-bit-time helper.
package can_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2
  } tx_state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  // Nominal bit time in time quanta: SYNC (1 TQ) + TSEG1 + TSEG2.
  function automatic int calc_nbt(input int tseg1, input int tseg2);
    return 1 + tseg1 + tseg2;
  endfunction

endpackage

// File: rtl/can_tq_counter.sv
// Prescaler and time-quantum counters for one CAN bit. Flags the last
// clock of the bit and the sample point. restart holds both counters at 0.
module can_tq_counter
  import can_timing_pkg::*;
#(
  parameter  int PRESCALER = 4,
  parameter  int TSEG1     = 13,
  parameter  int TSEG2     = 2,
  localparam int NBT       = calc_nbt(TSEG1, TSEG2),
  localparam int TQ_W      = $clog2(NBT),
  localparam int PRE_W     = (PRESCALER > 1) ? $clog2(PRESCALER) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            restart,
  output logic [TQ_W-1:0] tq_idx,
  output logic            bit_end,
  output logic            sample_point
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALER - 1);
  localparam logic [TQ_W-1:0]  TQ_LAST  = TQ_W'(NBT - 1);
  localparam logic [TQ_W-1:0]  SP_IDX   = TQ_W'(1 + TSEG1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [TQ_W-1:0]  r_tq_idx;
  logic             w_pre_last;

  // With PRESCALER=1 the prescaler is always at its last value, so it stays 0.
  assign w_pre_last = (r_pre_cnt == PRE_LAST);

  // Prescaler: counts clocks within one time quantum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (restart || w_pre_last) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  // TQ index: advances on each prescaler wrap, wraps at the end of the bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tq_idx <= '0;
    end else if (restart) begin
      r_tq_idx <= '0;
    end else if (w_pre_last) begin
      r_tq_idx <= (r_tq_idx == TQ_LAST) ? '0 : r_tq_idx + 1'b1;
    end
  end

  assign tq_idx       = r_tq_idx;
  assign bit_end      = (r_tq_idx == TQ_LAST) && w_pre_last;
  assign sample_point = (r_tq_idx == SP_IDX) && (r_pre_cnt == '0);

endmodule

// File: rtl/can_bit_transmitter.sv
// CAN transmit bit engine: accepts one bit per handshake, drives it for one
// nominal bit time, and inserts a complementary stuff bit after STUFF_LEN
// identical bits when stuffing is enabled for the bit that completes the run.
module can_bit_transmitter
  import can_timing_pkg::*;
#(
  parameter int PRESCALER = 4,
  parameter int TSEG1     = 13,
  parameter int TSEG2     = 2,
  parameter int STUFF_LEN = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_valid,
  input  logic bit_data,
  output logic bit_ready,
  input  logic stuff_en,
  output logic tx_out,
  output logic tx_point,
  output logic sample_point,
  output logic stuff_active,
  output logic busy
);

  localparam int NBT   = calc_nbt(TSEG1, TSEG2);
  localparam int TQ_W  = $clog2(NBT);
  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  tx_state_e        r_state;
  logic             r_tx_out;
  logic             r_tx_point;
  logic             r_last_bit;
  logic             r_stuff_pend;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] w_run_next;

  logic [TQ_W-1:0]  w_tq_idx;
  logic             w_bit_end;
  logic             w_sp;
  logic             w_busy;
  logic             w_accept;
  logic             w_to_stuff;

  assign w_busy = (r_state != IDLE);

  can_tq_counter #(
    .PRESCALER (PRESCALER),
    .TSEG1     (TSEG1),
    .TSEG2     (TSEG2)
  ) u_tq_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .restart      (~w_busy),
    .tq_idx       (w_tq_idx),
    .bit_end      (w_bit_end),
    .sample_point (w_sp)
  );

  // A pending stuff bit blocks the handshake so it goes out before the next data bit.
  assign bit_ready  = ~w_busy | (w_bit_end & ~r_stuff_pend);
  assign w_accept   = bit_valid & bit_ready;
  assign w_to_stuff = (r_state == DATA) & w_bit_end & r_stuff_pend;

  // Run length the incoming bit would produce; 0 means no run history.
  always_comb begin
    w_run_next = RUN_ONE;
    if ((r_run_cnt != '0) && (bit_data == r_last_bit)) begin
      w_run_next = (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + RUN_ONE;
    end
  end

  // Bit sequencing: data handshake, stuff insertion, return to idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_tx_out     <= CAN_RECESSIVE;
      r_tx_point   <= 1'b0;
      r_last_bit   <= CAN_RECESSIVE;
      r_stuff_pend <= 1'b0;
      r_run_cnt    <= '0;
    end else begin
      r_tx_point <= w_accept | w_to_stuff;
      if (w_accept) begin
        r_state    <= DATA;
        r_tx_out   <= bit_data;
        r_last_bit <= bit_data;
        if (stuff_en) begin
          r_run_cnt    <= w_run_next;
          r_stuff_pend <= (w_run_next == RUN_MAX);
        end else begin
          r_run_cnt    <= '0;
          r_stuff_pend <= 1'b0;
        end
      end else if (w_to_stuff) begin
        r_state      <= STUFF;
        r_tx_out     <= ~r_last_bit;
        r_last_bit   <= ~r_last_bit;
        r_run_cnt    <= RUN_ONE;
        r_stuff_pend <= 1'b0;
      end else if (w_busy && w_bit_end) begin
        r_state   <= IDLE;
        r_tx_out  <= CAN_RECESSIVE;
        r_run_cnt <= '0;
      end
    end
  end

  // Counters are held at zero whenever no bit is being driven.
  a_idle_counters_clear: assert property (
    @(posedge clock) disable iff (!reset_n) (r_state == IDLE) |-> (w_tq_idx == '0)
  );

  assign tx_out       = r_tx_out;
  assign tx_point     = r_tx_point;
  assign sample_point = w_sp & w_busy;
  assign stuff_active = (r_state == STUFF);
  assign busy         = w_busy;

endmodule
